// File: rtl/wb_b3_pkg.sv
// Wishbone B3 shared definitions for the line burst master.
// Contents: cycle-type and burst-type codes, the FSM state encoding and
// bte_for_words(), which maps a line length in words to its wrap code.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic [1:0] bte_for_words(input int n);
    case (n)
      4:       return BTE_WRAP4;
      8:       return BTE_WRAP8;
      16:      return BTE_WRAP16;
      default: return BTE_LINEAR;
    endcase
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Burst address generator for wb_line_burst_master.
// Holds the upper (above-line) address bits, the word offset inside the
// line and the beat counter; produces wb address, cti, bte and last-beat.
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   load_i         capture adr_i and arm a new burst
//   adr_i          requested byte address
//   ack_i          a beat completed normally (advance offset and counter)
//   clear_i        burst finished or aborted (return cti/bte to idle codes)
//   adr_o          Wishbone byte address
//   off_o          current word offset within the line (line slot index)
//   cti_o, bte_o   Wishbone cycle type / burst type
//   last_o         the current beat is the final one
// Build option: CRITICAL_WORD_FIRST_EN starts at the requested word and
// signals a wrapping burst; otherwise the burst is linear from word 0.
module wb_burst_adr_gen
  import wb_b3_pkg::*;
#(
  parameter int aw         = 32,
  parameter int line_words = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          load_i,
  input  logic [aw-1:0]                 adr_i,
  input  logic                          ack_i,
  input  logic                          clear_i,
  output logic [aw-1:0]                 adr_o,
  output logic [$clog2(line_words)-1:0] off_o,
  output logic [2:0]                    cti_o,
  output logic [1:0]                    bte_o,
  output logic                          last_o
);

  localparam int ow = $clog2(line_words);
  localparam int uw = aw - ow - 2;

  logic [uw-1:0] upper_q, upper_d;
  logic [ow-1:0] off_q, off_d;
  logic [3:0]    b_q, b_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;

  always_comb begin
    upper_d = upper_q;
    off_d   = off_q;
    b_d     = b_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    if (load_i) begin
      upper_d = adr_i[aw-1:ow+2];
      b_d     = 4'd0;
      cti_d   = CTI_INCR;
`ifdef CRITICAL_WORD_FIRST_EN
      off_d   = adr_i[ow+1:2];
      bte_d   = bte_for_words(line_words);
`else
      off_d   = '0;
      bte_d   = BTE_LINEAR;
`endif
    end else if (clear_i) begin
      cti_d = CTI_CLASSIC;
      bte_d = BTE_LINEAR;
    end else if (ack_i) begin
      // Offset is exactly ow bits wide, so the increment wraps in the line.
      off_d = off_q + 1'b1;
      b_d   = b_q + 4'd1;
      if (b_d == 4'(line_words - 1)) cti_d = CTI_EOB;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      upper_q <= '0;
      off_q   <= '0;
      b_q     <= 4'd0;
      cti_q   <= CTI_CLASSIC;
      bte_q   <= BTE_LINEAR;
    end else begin
      upper_q <= upper_d;
      off_q   <= off_d;
      b_q     <= b_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
    end
  end

  assign adr_o  = {upper_q, off_q, 2'b00};
  assign off_o  = off_q;
  assign cti_o  = cti_q;
  assign bte_o  = bte_q;
  assign last_o = (b_q == 4'(line_words - 1));

endmodule

// File: rtl/wb_line_burst_master.sv
// Cache-line refill/writeback Wishbone B3 master.
// Takes one whole-line request (req_*), runs it as a single registered-
// feedback incrementing burst, and returns the line / status on rsp_*.
// Wishbone side: wb_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o out,
// wb_dat_i/ack_i/err_i/rty_i in. err or rty abort the burst (rsp_err_o).
// Build option: CRITICAL_WORD_FIRST_EN (see wb_burst_adr_gen).
module wb_line_burst_master
  import wb_b3_pkg::*;
#(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int line_words = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [aw-1:0]            req_adr_i,
  input  logic [line_words*dw-1:0] req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_err_o,
  output logic [line_words*dw-1:0] rsp_rdata_o,
  output logic [aw-1:0]            wb_adr_o,
  output logic [dw-1:0]            wb_dat_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic [2:0]               wb_cti_o,
  output logic [1:0]               wb_bte_o,
  input  logic [dw-1:0]            wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i
);

  localparam int ow = $clog2(line_words);
  localparam int lw = line_words * dw;

  state_e        state_q, state_d;
  logic          pend_q, pend_d;   // request latched, burst launches next edge
  logic          dir_q, dir_d;     // 1 = writeback
  logic          cyc_q, cyc_d;
  logic          err_q, err_d;
  logic [lw-1:0] wdata_q, wdata_d;
  logic [lw-1:0] rdata_q, rdata_d;

  logic          load, beat_ack, beat_err, last, clear;
  logic [ow-1:0] off;

  // err/rty take priority over a simultaneous ack.
  assign beat_err = cyc_q & (wb_err_i | wb_rty_i);
  assign beat_ack = cyc_q & wb_ack_i & ~beat_err;
  assign load     = (state_q == ST_IDLE) & ~pend_q & req_valid_i;
  assign clear    = beat_err | (beat_ack & last);

  wb_burst_adr_gen #(.aw(aw), .line_words(line_words)) u_adr_gen (
    .clk     (wb_clk_i),
    .srst    (wb_rst_i),
    .load_i  (load),
    .adr_i   (req_adr_i),
    .ack_i   (beat_ack),
    .clear_i (clear),
    .adr_o   (wb_adr_o),
    .off_o   (off),
    .cti_o   (wb_cti_o),
    .bte_o   (wb_bte_o),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          cyc_d   = 1'b1;
          state_d = ST_BURST;
        end else if (req_valid_i) begin
          pend_d  = 1'b1;
          dir_d   = req_we_i;
          wdata_d = req_wdata_i;
          err_d   = 1'b0;
        end
      end
      ST_BURST: begin
        if (beat_err) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (beat_ack) begin
          // Slot is the beat's word offset, so line order is beat-order free.
          if (!dir_q) rdata_d[int'(off)*dw +: dw] = wb_dat_i;
          if (last) begin
            cyc_d   = 1'b0;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      dir_q   <= 1'b0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) & ~pend_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = cyc_q & dir_q;
  assign wb_sel_o    = cyc_q ? 4'hf : 4'h0;
  assign wb_dat_o    = wdata_q[int'(off)*dw +: dw];

endmodule

// File: tb/tb_wb_line_burst_master.sv
module tb_wb_line_burst_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_adr;
  logic [127:0] req_wdata;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [127:0] rsp_rdata;
  logic [31:0]  wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]   wb_sel;
  logic         wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
  logic [2:0]   wb_cti;
  logic [1:0]   wb_bte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_line_burst_master #(.dw(32), .aw(32), .line_words(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err),
    .rsp_rdata_o(rsp_rdata),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
  );

  // Zero-wait RAM slave with optional stall / error injection.
  logic [31:0] mem [0:255];
  int   err_at = -1, stall_at = -1, stall_n = 0;
  int   beat_cnt = 0, stall_cnt = 0;
  logic pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_dat = 32'd0;
  logic stalled, hit;

  assign stalled  = (beat_cnt == stall_at) && (stall_cnt < stall_n);
  assign hit      = wb_cyc & wb_stb & ~stalled;
  assign wb_ack   = hit & (beat_cnt != err_at);
  assign wb_err   = hit & (beat_cnt == err_at);
  assign wb_rty   = 1'b0;
  assign wb_dat_i = mem[wb_adr[9:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_dat;
    if (wb_ack && wb_we) mem[wb_adr[9:2]] <= wb_dat_o;
    if (!wb_cyc) begin
      beat_cnt  <= 0;
      stall_cnt <= 0;
    end else if (stalled) begin
      stall_cnt <= stall_cnt + 1;
    end else if (wb_ack || wb_err) begin
      beat_cnt <= beat_cnt + 1;
    end
  end

  // Beat log: one entry per completed (acked or errored) beat.
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic [2:0]  log_cti [0:63];
  logic [1:0]  log_bte [0:63];
  logic [3:0]  log_sel [0:63];
  logic        log_we  [0:63];
  int log_n = 0;

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && (wb_ack || wb_err) && log_n < 64) begin
      log_adr[log_n] <= wb_adr;
      log_dat[log_n] <= wb_dat_o;
      log_cti[log_n] <= wb_cti;
      log_bte[log_n] <= wb_bte;
      log_sel[log_n] <= wb_sel;
      log_we[log_n]  <= wb_we;
      log_n <= log_n + 1;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] EXP_BTE = 2'b01;
`else
  localparam logic [1:0] EXP_BTE = 2'b00;
`endif
  localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] LINE_D = 128'h000000D3_000000D2_000000D1_000000D0;
  localparam logic [127:0] LINE_E = 128'h000000E3_000000E2_000000E1_000000E0;

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_dat = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issues one request. lat counts posedges from the accept edge (inclusive)
  // up to the one after which rsp_valid is first seen high.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [127:0] wd,
                        input int hold, input logic probe, input logic [31:0] p_adr,
                        input logic [31:0] p_dat, output int lat, output logic [127:0] rd,
                        output logic er, output int first);
    int w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    first = log_n;
    req_we = we; req_adr = adr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (probe && stalled) begin
        checks++;
        if (wb_adr !== p_adr || wb_dat_o !== p_dat || wb_cti !== 3'b010) begin
          errors++;
          $display("FAIL stall_hold: adr=%h dat=%h cti=%b required adr=%h dat=%h cti=010",
                   wb_adr, wb_dat_o, wb_cti, p_adr, p_dat);
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er) begin
        errors++;
        $display("FAIL rsp_hold: cycle %0d valid=%b required 1 with stable data", i, rsp_valid);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err} !== 6'b100000 ||
        wb_adr !== 32'd0 || wb_dat_o !== 32'd0 || wb_sel !== 4'h0 ||
        wb_cti !== 3'b000 || wb_bte !== 2'b00) begin
      errors++;
      $display("FAIL reset: rdy=%b cyc=%b stb=%b we=%b rv=%b re=%b adr=%h dat=%h sel=%h cti=%b bte=%b required rdy=1, rest 0",
               req_ready, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, wb_adr, wb_dat_o, wb_sel, wb_cti, wb_bte);
    end
    $display("test_reset done");
  endtask

  task automatic test_refill();
    int lat, first; logic [127:0] rd; logic er;
    do_req(1'b0, 32'h100, '0, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (lat !== 6 || rd !== LINE_A || er !== 1'b0 || log_n - first !== 4) begin
      errors++;
      $display("FAIL refill_rsp: lat=%0d rd=%h err=%b beats=%0d required 6 %h 0 4",
               lat, rd, er, log_n - first, LINE_A);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_adr[first+i] !== 32'h100 + 32'(4*i) || log_cti[first+i] !== (i == 3 ? 3'b111 : 3'b010) ||
          log_bte[first+i] !== EXP_BTE || log_we[first+i] !== 1'b0) begin
        errors++;
        $display("FAIL refill_beat%0d: adr=%h cti=%b bte=%b we=%b required adr=%h",
                 i, log_adr[first+i], log_cti[first+i], log_bte[first+i], log_we[first+i], 32'h100 + 32'(4*i));
      end
    end
    $display("test_refill: lat=%0d rdata=%h", lat, rd);
  endtask

  task automatic test_critical_word();
    int lat, first; logic [127:0] rd; logic er;
    logic [31:0] exp_adr [0:3];
`ifdef CRITICAL_WORD_FIRST_EN
    exp_adr = '{32'h108, 32'h10C, 32'h100, 32'h104};
`else
    exp_adr = '{32'h100, 32'h104, 32'h108, 32'h10C};
`endif
    do_req(1'b0, 32'h108, '0, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (rd !== LINE_A || er !== 1'b0) begin
      errors++;
      $display("FAIL cwf_rsp: rd=%h err=%b required %h 0", rd, er, LINE_A);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_adr[first+i] !== exp_adr[i] || log_bte[first+i] !== EXP_BTE) begin
        errors++;
        $display("FAIL cwf_beat%0d: adr=%h bte=%b required %h %b",
                 i, log_adr[first+i], log_bte[first+i], exp_adr[i], EXP_BTE);
      end
    end
    $display("test_critical_word: first adr=%h", log_adr[first]);
  endtask

  task automatic test_writeback();
    int lat, first; logic [127:0] rd; logic er;
    do_req(1'b1, 32'h200, LINE_D, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (lat !== 6 || er !== 1'b0 || log_n - first !== 4) begin
      errors++;
      $display("FAIL wb_rsp: lat=%0d err=%b beats=%0d required 6 0 4", lat, er, log_n - first);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_we[first+i] !== 1'b1 || log_sel[first+i] !== 4'hf ||
          log_adr[first+i] !== 32'h200 + 32'(4*i) || log_dat[first+i] !== 32'hD0 + 32'(i)) begin
        errors++;
        $display("FAIL wb_beat%0d: we=%b sel=%h adr=%h dat=%h required 1 f %h %h", i, log_we[first+i],
                 log_sel[first+i], log_adr[first+i], log_dat[first+i], 32'h200 + 32'(4*i), 32'hD0 + 32'(i));
      end
    end
    do_req(1'b0, 32'h200, '0, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (rd !== LINE_D || er !== 1'b0) begin
      errors++;
      $display("FAIL wb_readback: rd=%h err=%b required %h 0", rd, er, LINE_D);
    end
    $display("test_writeback: readback=%h", rd);
  endtask

  task automatic test_wait_states();
    int lat, first; logic [127:0] rd; logic er;
    stall_at = 2; stall_n = 2;
    do_req(1'b1, 32'h300, LINE_E, 0, 1'b1, 32'h308, 32'hE2, lat, rd, er, first);
    checks++;
    if (lat !== 8 || er !== 1'b0 || log_n - first !== 4 || log_dat[first+2] !== 32'hE2) begin
      errors++;
      $display("FAIL wait_burst: lat=%0d err=%b beats=%0d dat2=%h required 8 0 4 e2",
               lat, er, log_n - first, log_dat[first+2]);
    end
    stall_at = -1; stall_n = 0;
    do_req(1'b0, 32'h300, '0, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (rd !== LINE_E) begin
      errors++;
      $display("FAIL wait_readback: rd=%h required %h", rd, LINE_E);
    end
    $display("test_wait_states: readback=%h", rd);
  endtask

  task automatic test_error();
    int lat, first; logic [127:0] rd; logic er;
    err_at = 1;
    do_req(1'b0, 32'h100, '0, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (lat !== 4 || er !== 1'b1 || log_n - first !== 2) begin
      errors++;
      $display("FAIL err_abort: lat=%0d err=%b beats=%0d required 4 1 2", lat, er, log_n - first);
    end
    err_at = -1;
    do_req(1'b0, 32'h100, '0, 0, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (lat !== 6 || rd !== LINE_A || er !== 1'b0) begin
      errors++;
      $display("FAIL err_recover: lat=%0d rd=%h err=%b required 6 %h 0", lat, rd, er, LINE_A);
    end
    $display("test_error: recovered rdata=%h", rd);
  endtask

  task automatic test_reset_mid_burst();
    int w = 0, first, lat; logic [127:0] rd; logic er; logic seen = 1'b0;
    first = log_n;
    req_we = 1'b0; req_adr = 32'h100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (log_n - first < 2 && w < 50) begin @(posedge clk); #1; w++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: cyc=%b stb=%b rv=%b rdy=%b required 0 0 0 1", wb_cyc, wb_stb, rsp_valid, req_ready);
    end
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rsp: rsp_valid seen=%b required 0", seen);
    end
    do_req(1'b0, 32'h100, '0, 3, 1'b0, 0, 0, lat, rd, er, first);
    checks++;
    if (rd !== LINE_A || er !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: rd=%h err=%b required %h 0", rd, er, LINE_A);
    end
    $display("test_reset_mid_burst: post-reset rdata=%h", rd);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) preload(8'(64 + i), 32'hA0 + 32'(i));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_refill();
    test_critical_word();
    test_writeback();
    test_wait_states();
    test_error();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
